// File: rtl/crono_pkg.sv
// Shared definitions for the sprint stopwatch: state codes, default clocking and width helper.
package crono_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FIN   = 3'd3;
  localparam logic [2:0] ST_FALSE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SET   = ST_SET,
    S_RUN   = ST_RUN,
    S_FIN   = ST_FIN,
    S_FALSE = ST_FALSE
  } state_t;

  localparam int DEF_CLK_FREQ = 25_000_000;
  localparam int DEF_TICK_HZ  = 100;

  function automatic int tw_of(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Timing prescaler: emits a one-cycle wrap pulse every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int CLK_FREQ = crono_pkg::DEF_CLK_FREQ,
  parameter int TICK_HZ  = crono_pkg::DEF_TICK_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt;

  assign tick = en & (cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/sprint_race_ctrl.sv
// Sprint stopwatch sequencer: arms on start, times the race in ticks, flags false starts
// and captures the reaction time when the athlete leaves the blocks.
module sprint_race_ctrl
  import crono_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int TICK_HZ  = DEF_TICK_HZ,
  parameter int SET_MS   = 2000,
  parameter int MAX_CNT  = 99_999,
  localparam int TW      = tw_of(MAX_CNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_start,
  input  logic          btn_reset,
  input  logic          block_sensor,
  input  logic          finish_sensor,
  output logic [TW-1:0] time_cnt,
  output logic [TW-1:0] reaction_cnt,
  output logic          reaction_vld,
  output logic [2:0]    state_o,
  output logic          tick,
  output logic          finished,
  output logic          false_start,
  output logic          overflow
);
  localparam int SET_CYC = (CLK_FREQ / 1000) * SET_MS;
  localparam int SW      = (SET_CYC > 1) ? $clog2(SET_CYC) : 1;

  state_t        state, state_n;
  logic [SW-1:0] set_cnt;
  logic          start_q, reset_q, block_q, finish_q;
  logic          rise_start, rise_reset, rise_finish, rel;
  logic          tick_raw, sat, set_done;

  // History resets high so a level held through reset never reads as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b1;
      reset_q  <= 1'b1;
      block_q  <= 1'b1;
      finish_q <= 1'b1;
    end else begin
      start_q  <= btn_start;
      reset_q  <= btn_reset;
      block_q  <= block_sensor;
      finish_q <= finish_sensor;
    end
  end

  assign rise_start  = btn_start & ~start_q;
  assign rise_reset  = btn_reset & ~reset_q;
  assign rise_finish = finish_sensor & ~finish_q;
  assign rel         = ~block_sensor & block_q;
  assign sat         = (time_cnt == TW'(MAX_CNT));
  assign set_done    = (set_cnt == SW'(SET_CYC - 1));

  tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_SET),
    .en   (state == S_RUN),
    .tick (tick_raw)
  );

  // The saturating wrap ends the race instead of counting, so it is not reported as a tick.
  assign tick    = tick_raw & ~sat;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (rise_reset) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (rise_start && block_sensor) state_n = S_SET;
        S_SET:   if (rel) state_n = S_FALSE;
                 else if (set_done) state_n = S_RUN;
        S_RUN:   if (rise_finish || (tick_raw && sat)) state_n = S_FIN;
        S_FIN, S_FALSE: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rise_reset) begin
      time_cnt     <= '0;
      reaction_cnt <= '0;
      reaction_vld <= 1'b0;
      finished     <= 1'b0;
      false_start  <= 1'b0;
      overflow     <= 1'b0;
      set_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          time_cnt <= '0;
          set_cnt  <= '0;
        end
        S_SET: begin
          set_cnt <= set_cnt + 1'b1;
          if (rel) false_start <= 1'b1;
        end
        S_RUN: begin
          if (tick_raw) begin
            if (sat) begin
              overflow <= 1'b1;
              finished <= 1'b1;
            end else begin
              time_cnt <= time_cnt + 1'b1;
            end
          end
          if (rise_finish) finished <= 1'b1;
          // Reaction records the pre-tick count of the cycle the blocks were released.
          if (rel && !reaction_vld) begin
            reaction_cnt <= time_cnt;
            reaction_vld <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sprint_race_ctrl.sv
// Directed bench for sprint_race_ctrl with a cycle-level behavioural model compared every cycle.
module tb_sprint_race_ctrl;
  localparam int MAXC = 20;
  localparam int DIV  = 10;
  localparam int SETC = 5;

  logic       clk = 1'b0, rst = 1'b1;
  logic       btn_start = 1'b0, btn_reset = 1'b0, block_sensor = 1'b0, finish_sensor = 1'b0;
  logic [4:0] time_cnt, reaction_cnt;
  logic       reaction_vld, tick, finished, false_start, overflow;
  logic [2:0] state_o;

  sprint_race_ctrl #(.CLK_FREQ(1000), .TICK_HZ(100), .SET_MS(5), .MAX_CNT(MAXC)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_reset(btn_reset),
    .block_sensor(block_sensor), .finish_sensor(finish_sensor),
    .time_cnt(time_cnt), .reaction_cnt(reaction_cnt), .reaction_vld(reaction_vld),
    .state_o(state_o), .tick(tick), .finished(finished), .false_start(false_start),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  // Model: state codes, race time, cycles spent in SET / RUNNING since entry.
  int m_state = 0, m_time = 0, m_react = 0, run_cyc = 0, set_cyc = 0;
  bit m_vld = 0, m_fin = 0, m_fs = 0, m_ovf = 0;
  bit p_start = 1, p_reset = 1, p_block = 1, p_fin = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk({name, " dut"}, dut_v, exp);
    chk({name, " model"}, mdl_v, exp);
  endtask

  function automatic bit m_tick();
    return (m_state == 2) && (run_cyc % DIV == DIV - 1) && (m_time != MAXC);
  endfunction

  always @(posedge clk) begin
    bit rs, rr, rf, rl, tk;
    rs = btn_start && !p_start;
    rr = btn_reset && !p_reset;
    rf = finish_sensor && !p_fin;
    rl = !block_sensor && p_block;
    tk = (m_state == 2) && (run_cyc % DIV == DIV - 1);
    if (rst) begin
      m_state = 0; m_time = 0; m_react = 0; run_cyc = 0; set_cyc = 0;
      m_vld = 0; m_fin = 0; m_fs = 0; m_ovf = 0;
      p_start = 1; p_reset = 1; p_block = 1; p_fin = 1;
    end else begin
      if (rr) begin
        m_state = 0; m_time = 0; m_react = 0; m_vld = 0; m_fin = 0; m_fs = 0; m_ovf = 0;
      end else begin
        case (m_state)
          0: if (rs && block_sensor) begin m_state = 1; set_cyc = 0; end
          1: begin
            if (rl) begin m_state = 4; m_fs = 1; end
            else if (set_cyc == SETC - 1) begin m_state = 2; run_cyc = 0; end
            else set_cyc++;
          end
          2: begin
            if (rl && !m_vld) begin m_react = m_time; m_vld = 1; end
            if (tk) begin
              if (m_time == MAXC) begin m_ovf = 1; m_fin = 1; m_state = 3; end
              else m_time++;
            end
            if (rf) begin m_fin = 1; m_state = 3; end
            run_cyc++;
          end
          default: ;
        endcase
      end
      p_start = btn_start; p_reset = btn_reset; p_block = block_sensor; p_fin = finish_sensor;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state_o, m_state);
      chk("time_cnt", time_cnt, m_time);
      chk("reaction_cnt", reaction_cnt, m_react);
      chk("reaction_vld", reaction_vld, m_vld);
      chk("tick", tick, m_tick());
      chk("finished", finished, m_fin);
      chk("false_start", false_start, m_fs);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
  endtask

  task automatic pulse_reset();
    btn_reset = 1'b1; cyc(1); btn_reset = 1'b0; cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(2);
    chk_en = 1'b1;
    lit("rst state", state_o, m_state, 0);
    lit("rst time", time_cnt, m_time, 0);
    chk("rst flags", {reaction_vld, finished, false_start, overflow, tick}, 0);
    block_sensor = 1'b1;
    rst = 1'b0;
    cyc(1);

    // 1: normal race
    pulse_start();
    lit("t1 set", state_o, m_state, 1);
    cyc(5);
    lit("t1 running", state_o, m_state, 2);
    cyc(23);
    lit("t1 time@23", time_cnt, m_time, 2);
    block_sensor = 1'b0; cyc(1);
    lit("t1 reaction", reaction_cnt, m_react, 2);
    lit("t1 reaction_vld", reaction_vld, m_vld, 1);
    cyc(51);
    finish_sensor = 1'b1; cyc(1);
    lit("t1 fin state", state_o, m_state, 3);
    lit("t1 fin time", time_cnt, m_time, 7);
    lit("t1 finished", finished, m_fin, 1);
    finish_sensor = 1'b0; block_sensor = 1'b1;
    pulse_reset();
    lit("t1 reset idle", state_o, m_state, 0);

    // 2: false start
    pulse_start();
    cyc(3);
    block_sensor = 1'b0; cyc(1);
    lit("t2 false state", state_o, m_state, 4);
    lit("t2 false_start", false_start, m_fs, 1);
    lit("t2 time", time_cnt, m_time, 0);
    block_sensor = 1'b1;
    pulse_start(); cyc(1);
    pulse_start(); cyc(1);
    lit("t2 start ignored", state_o, m_state, 4);
    pulse_reset();
    lit("t2 reset idle", state_o, m_state, 0);
    lit("t2 flag cleared", false_start, m_fs, 0);

    // 3: guards
    block_sensor = 1'b0; cyc(1);
    pulse_start(); cyc(1);
    lit("t3 no block", state_o, m_state, 0);
    finish_sensor = 1'b1; block_sensor = 1'b1; cyc(1);
    pulse_start();
    cyc(5);
    cyc(15);
    lit("t3 finish held", state_o, m_state, 2);
    finish_sensor = 1'b0; cyc(1);
    finish_sensor = 1'b1; cyc(1);
    lit("t3 fresh rise", state_o, m_state, 3);
    lit("t3 time", time_cnt, m_time, 1);
    finish_sensor = 1'b0;
    pulse_reset();

    // 4: overflow
    pulse_start();
    cyc(5);
    cyc(200);
    lit("t4 time@200", time_cnt, m_time, 20);
    lit("t4 still running", state_o, m_state, 2);
    cyc(20);
    lit("t4 state", state_o, m_state, 3);
    lit("t4 time", time_cnt, m_time, 20);
    lit("t4 overflow", overflow, m_ovf, 1);
    lit("t4 finished", finished, m_fin, 1);
    pulse_reset();

    // 5: simultaneous events
    pulse_start();
    cyc(5);
    cyc(79);
    finish_sensor = 1'b1; cyc(1);
    lit("t5 finish on tick", time_cnt, m_time, 8);
    finish_sensor = 1'b0;
    pulse_reset();
    pulse_start();
    cyc(4);
    block_sensor = 1'b0; cyc(1);
    lit("t5 rel on timeout", state_o, m_state, 4);
    block_sensor = 1'b1;
    pulse_reset();
    pulse_start();
    cyc(5);
    cyc(12);
    finish_sensor = 1'b1; btn_reset = 1'b1; cyc(1);
    lit("t5 reset beats finish", state_o, m_state, 0);
    lit("t5 finished clear", finished, m_fin, 0);
    finish_sensor = 1'b0; btn_reset = 1'b0; cyc(1);

    // 6: rst mid-race with buttons held
    pulse_start();
    cyc(5);
    cyc(40);
    lit("t6 time@40", time_cnt, m_time, 4);
    btn_start = 1'b1; btn_reset = 1'b1; rst = 1'b1; cyc(1);
    lit("t6 rst state", state_o, m_state, 0);
    lit("t6 rst time", time_cnt, m_time, 0);
    rst = 1'b0; cyc(3);
    lit("t6 held buttons", state_o, m_state, 0);
    btn_start = 1'b0; btn_reset = 1'b0; cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
